// File: rtl/vx_barrier_ctl.sv
`default_nettype none
// ============================================================================
// Module      : vx_barrier_ctl
// Description : Consumer end of the warp-control barrier channel. Accepts one
//               barrier request per cycle and tracks arrival count, waiting-warp
//               mask and phase per barrier entry. Returns a registered
//               warp-unlock pulse/mask to the scheduler (latency 1). Also
//               provides a combinational phase lookup for the barrier_phase
//               result path.
// Ports       : clk            core clock
//               reset          asynchronous, active-low reset
//               bar_valid      request strobe (always accepted)
//               bar_wid        requesting warp
//               bar_id         barrier index (out-of-range ids are ignored)
//               bar_is_async   0: sync barrier, 1: async arrive/wait
//               bar_is_arrive  async only: 1 = arrive, 0 = wait
//               bar_phase      async wait: phase the warp waits on
//               bar_size_m1    participating warps minus 1
//               phase_rd_id    phase lookup index
//               phase_rd       current phase of entry phase_rd_id
//               unlock_valid   one-cycle release pulse
//               unlock_mask    warps to release (valid with unlock_valid)
//               perf_bar_done  [BAR_PERF_EN] barrier completions (wrapping)
//               perf_bar_stalls[BAR_PERF_EN] accumulated stalled-warp cycles
// Config      : BAR_PERF_EN  defined -> adds perf_bar_done/perf_bar_stalls
// Revision    : 1.0  initial release
// ============================================================================
module vx_barrier_ctl #(
  parameter INSTANCE_ID  = "",
  parameter NUM_WARPS    = 4,
  parameter NUM_BARRIERS = 4,
  localparam NW_BITS     = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1,
  localparam NB_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic                 bar_is_async,
  input  logic                 bar_is_arrive,
  input  logic                 bar_phase,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  input  logic [NB_BITS-1:0]   phase_rd_id,
  output logic                 phase_rd,
  output logic                 unlock_valid,
  output logic [NUM_WARPS-1:0] unlock_mask
`ifdef BAR_PERF_EN
  ,
  output logic [31:0]          perf_bar_done,
  output logic [31:0]          perf_bar_stalls
`endif
);

  // Debug tag only; no hardware is generated for it.
  if (INSTANCE_ID != "") begin : g_debug_tag
  end

  // Per-entry state
  logic [NW_BITS-1:0]   r_count [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] r_wmask [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] r_phase;

  // Resolution of the current request against its entry
  logic                 w_hit;
  logic                 w_done;
  logic                 w_complete;
  logic                 w_release;
  logic [NUM_WARPS-1:0] w_release_mask;
  logic [NUM_WARPS-1:0] w_onehot;
  logic [NW_BITS-1:0]   w_cnt_nxt;
  logic [NUM_WARPS-1:0] w_wm_nxt;
  logic                 w_ph_nxt;

  // Lookup returns the pre-update phase, which is what an arriving warp's
  // result must carry, so no bypass from the update path is needed.
  always_comb begin
    phase_rd = 1'b0;
    if (32'(phase_rd_id) < NUM_BARRIERS) phase_rd = r_phase[phase_rd_id];
  end

  always_comb begin
    w_hit          = bar_valid && (32'(bar_id) < NUM_BARRIERS);
    w_onehot       = NUM_WARPS'(1) << bar_wid;
    w_done         = (r_count[bar_id] == bar_size_m1);
    w_cnt_nxt      = r_count[bar_id];
    w_wm_nxt       = r_wmask[bar_id];
    w_ph_nxt       = r_phase[bar_id];
    w_release      = 1'b0;
    w_release_mask = '0;
    w_complete     = 1'b0;
    if (w_hit) begin
      if (!bar_is_async || bar_is_arrive) begin
        // Arrival (sync, or async arrive)
        if (w_done) begin
          w_complete     = 1'b1;
          w_release      = 1'b1;
          // A sync arriver is itself stalled and joins the release; an async
          // arriver never stalls. Release fires even with an empty mask.
          w_release_mask = r_wmask[bar_id] | (bar_is_async ? '0 : w_onehot);
          w_cnt_nxt      = '0;
          w_wm_nxt       = '0;
          w_ph_nxt       = ~r_phase[bar_id];
        end else begin
          w_cnt_nxt = r_count[bar_id] + NW_BITS'(1);
          if (!bar_is_async) w_wm_nxt = r_wmask[bar_id] | w_onehot;
        end
      end else begin
        // Async wait: a phase mismatch means the awaited phase already
        // completed, so the waiter is released at once with no state change.
        if (bar_phase != r_phase[bar_id]) begin
          w_release      = 1'b1;
          w_release_mask = w_onehot;
        end else begin
          w_wm_nxt = r_wmask[bar_id] | w_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        r_count[i] <= '0;
        r_wmask[i] <= '0;
      end
      r_phase      <= '0;
      unlock_valid <= 1'b0;
      unlock_mask  <= '0;
    end else begin
      unlock_valid <= w_release;
      unlock_mask  <= w_release_mask;
      if (w_hit) begin
        r_count[bar_id] <= w_cnt_nxt;
        r_wmask[bar_id] <= w_wm_nxt;
        r_phase[bar_id] <= w_ph_nxt;
      end
    end
  end

`ifdef BAR_PERF_EN
  // Warps currently parked on any barrier, counted once per cycle.
  logic [NUM_WARPS-1:0] w_stalled;
  always_comb begin
    w_stalled = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) w_stalled = w_stalled | r_wmask[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bar_done   <= '0;
      perf_bar_stalls <= '0;
    end else begin
      perf_bar_done   <= perf_bar_done + 32'(w_complete);
      perf_bar_stalls <= perf_bar_stalls + 32'($countones(w_stalled));
    end
  end
`else
  // Completion flag only feeds the performance counters.
  logic w_unused_complete;
  assign w_unused_complete = w_complete;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_barrier_ctl
// Description : Self-checking bench for vx_barrier_ctl (4 warps, 4 barriers).
//               Directed scenarios plus random traffic against a reference
//               model of the barrier rules kept in plain integer arrays.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vx_barrier_ctl;

  localparam int NW = 4;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       bar_valid;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic       bar_is_async;
  logic       bar_is_arrive;
  logic       bar_phase;
  logic [1:0] bar_size_m1;
  logic [1:0] phase_rd_id;
  logic       phase_rd;
  logic       unlock_valid;
  logic [3:0] unlock_mask;
`ifdef BAR_PERF_EN
  logic [31:0] perf_bar_done;
  logic [31:0] perf_bar_stalls;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model
  int       m_cnt [NB];
  bit [3:0] m_wm  [NB];
  bit       m_ph  [NB];
  int       m_done;
  int       m_stall;
  bit       exp_uv;
  bit [3:0] exp_um;

  vx_barrier_ctl #(
    .INSTANCE_ID  ("tb"),
    .NUM_WARPS    (NW),
    .NUM_BARRIERS (NB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bar_valid     (bar_valid),
    .bar_wid       (bar_wid),
    .bar_id        (bar_id),
    .bar_is_async  (bar_is_async),
    .bar_is_arrive (bar_is_arrive),
    .bar_phase     (bar_phase),
    .bar_size_m1   (bar_size_m1),
    .phase_rd_id   (phase_rd_id),
    .phase_rd      (phase_rd),
    .unlock_valid  (unlock_valid),
    .unlock_mask   (unlock_mask)
`ifdef BAR_PERF_EN
    ,
    .perf_bar_done   (perf_bar_done),
    .perf_bar_stalls (perf_bar_stalls)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_cnt[i] = 0;
      m_wm[i]  = '0;
      m_ph[i]  = 1'b0;
    end
    m_done  = 0;
    m_stall = 0;
    exp_uv  = 1'b0;
    exp_um  = '0;
  endfunction

  // One clock cycle with an optional request; the model is advanced at the
  // edge and exp_uv/exp_um hold the release expected after that edge.
  task automatic cycle(input bit v, input int wid, input int id, input bit isa,
                       input bit arr, input bit ph, input int sz);
    bit [3:0] me;
    bit [3:0] stalled;
    @(negedge clk);
    bar_valid     = v;
    bar_wid       = 2'(wid);
    bar_id        = 2'(id);
    bar_is_async  = isa;
    bar_is_arrive = arr;
    bar_phase     = ph;
    bar_size_m1   = 2'(sz);
    @(posedge clk);
    stalled = '0;
    for (int i = 0; i < NB; i++) stalled |= m_wm[i];
    m_stall += $countones(stalled);
    exp_uv = 1'b0;
    exp_um = '0;
    if (v && id < NB) begin
      me = 4'b0001 << wid;
      if (!isa || arr) begin
        if (m_cnt[id] == sz) begin
          exp_uv = 1'b1;
          exp_um = isa ? m_wm[id] : (m_wm[id] | me);
          m_cnt[id] = 0;
          m_wm[id]  = '0;
          m_ph[id]  = !m_ph[id];
          m_done++;
        end else begin
          m_cnt[id] = (m_cnt[id] + 1) % NW;
          if (!isa) m_wm[id] |= me;
        end
      end else if (ph != m_ph[id]) begin
        exp_uv = 1'b1;
        exp_um = me;
      end else begin
        m_wm[id] |= me;
      end
    end
    #1;
    bar_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bar_valid = 1'b0; bar_wid = '0; bar_id = '0; bar_is_async = 1'b0;
    bar_is_arrive = 1'b0; bar_phase = 1'b0; bar_size_m1 = '0; phase_rd_id = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_unlock_valid: got %b expected 0", unlock_valid);
    end
    for (int i = 0; i < NB; i++) begin
      phase_rd_id = 2'(i);
      #1;
      tests++;
      if (phase_rd !== 1'b0) begin
        fails++;
        $display("FAIL reset_phase[%0d]: got %b expected 0", i, phase_rd);
      end
    end
  endtask

  task automatic test_sync();
    int wids [3] = '{0, 2, 3};
    for (int k = 0; k < 3; k++) begin
      cycle(1, wids[k], 1, 0, 0, 0, 2);
      tests++;
      if (unlock_valid !== (k == 2)) begin
        fails++;
        $display("FAIL sync_valid step %0d: got %b expected %b", k, unlock_valid, k == 2);
      end
    end
    tests++;
    if (unlock_mask !== 4'b1101) begin
      fails++;
      $display("FAIL sync_mask: got %b expected 1101", unlock_mask);
    end
    phase_rd_id = 2'd1;
    #1;
    tests++;
    if (phase_rd !== 1'b1) begin
      fails++;
      $display("FAIL sync_phase: got %b expected 1", phase_rd);
    end
`ifdef BAR_PERF_EN
    tests++;
    if (perf_bar_done !== 32'd1 || perf_bar_stalls !== 32'd3) begin
      fails++;
      $display("FAIL perf_sync: done %0d stalls %0d expected 1 3", perf_bar_done, perf_bar_stalls);
    end
`endif
  endtask

  task automatic test_async();
    cycle(1, 1, 0, 1, 0, 0, 1);  // wait w1 on phase 0
    cycle(1, 2, 0, 1, 1, 0, 1);  // arrive w2
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_early: got %b expected 0", unlock_valid);
    end
    cycle(1, 3, 0, 1, 1, 0, 1);  // arrive w3 completes
    tests++;
    if (unlock_valid !== 1'b1 || unlock_mask !== 4'b0010) begin
      fails++;
      $display("FAIL async_release: got %b/%b expected 1/0010", unlock_valid, unlock_mask);
    end
    phase_rd_id = 2'd0;
    #1;
    tests++;
    if (phase_rd !== 1'b1) begin
      fails++;
      $display("FAIL async_phase: got %b expected 1", phase_rd);
    end
    // Late waiter on the already-completed phase 0
    cycle(1, 0, 0, 1, 0, 0, 1);
    tests++;
    if (unlock_valid !== 1'b1 || unlock_mask !== 4'b0001) begin
      fails++;
      $display("FAIL async_late_wait: got %b/%b expected 1/0001", unlock_valid, unlock_mask);
    end
    // Count must be unchanged (0): one more arrive must not complete size 2
    cycle(1, 1, 0, 1, 1, 0, 1);
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_count_kept: got %b expected 0", unlock_valid);
    end
    cycle(1, 2, 0, 1, 1, 0, 1);  // second arrive completes, empty mask
    tests++;
    if (unlock_valid !== 1'b1 || unlock_mask !== 4'b0000) begin
      fails++;
      $display("FAIL async_empty_release: got %b/%b expected 1/0000", unlock_valid, unlock_mask);
    end
  endtask

  task automatic test_size0();
    cycle(1, 3, 2, 0, 0, 0, 0);
    tests++;
    if (unlock_valid !== 1'b1 || unlock_mask !== 4'b1000) begin
      fails++;
      $display("FAIL size0_release: got %b/%b expected 1/1000", unlock_valid, unlock_mask);
    end
    phase_rd_id = 2'd2;
    #1;
    tests++;
    if (phase_rd !== 1'b1) begin
      fails++;
      $display("FAIL size0_phase: got %b expected 1", phase_rd);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_pulse: got %b expected 0", unlock_valid);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 1, 0, 0, 0, 2);
    cycle(1, 2, 1, 0, 0, 0, 2);
    cycle(1, 1, 3, 0, 0, 0, 0);  // leaves an unlock pulse registered
    reset = 1'b0;
    #1;
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_unlock: got %b expected 0", unlock_valid);
    end
    for (int i = 0; i < NB; i++) begin
      phase_rd_id = 2'(i);
      #1;
      tests++;
      if (phase_rd !== 1'b0) begin
        fails++;
        $display("FAIL midreset_phase[%0d]: got %b expected 0", i, phase_rd);
      end
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 3, 1, 0, 0, 0, 2);  // count restarted: no release yet
    tests++;
    if (unlock_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_count: got %b expected 0", unlock_valid);
    end
  endtask

  task automatic test_random();
    int rid;
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3));
      tests++;
      if (unlock_valid !== exp_uv || (exp_uv && unlock_mask !== exp_um)) begin
        fails++;
        $display("FAIL random_unlock n=%0d: got %b/%b expected %b/%b",
                 n, unlock_valid, unlock_mask, exp_uv, exp_um);
      end
      rid = $urandom_range(0, 3);
      phase_rd_id = 2'(rid);
      #1;
      tests++;
      if (phase_rd !== m_ph[rid]) begin
        fails++;
        $display("FAIL random_phase n=%0d id=%0d: got %b expected %b", n, rid, phase_rd, m_ph[rid]);
      end
    end
`ifdef BAR_PERF_EN
    tests++;
    if (perf_bar_done !== 32'(m_done) || perf_bar_stalls !== 32'(m_stall)) begin
      fails++;
      $display("FAIL perf_random: done %0d stalls %0d expected %0d %0d",
               perf_bar_done, perf_bar_stalls, m_done, m_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sync();
    test_async();
    test_size0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
